// File: rtl/rv32i_decode_stage_if.sv
// Fetch-to-decode, write-back and ID/EX signal bundle for the RV32I decode stage.
// master = surrounding pipeline, slave = the decode stage itself.
interface rv32i_decode_stage_if;
  // Fetch side and pipeline control
  logic [31:0] iw_in;
  logic [31:0] pc_in;
  logic        valid_in;
  logic        stall;
  logic        flush;
  // Write-back port from the last pipeline stage
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  // ID/EX pipeline register
  logic [31:0] iw_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm_out;
  logic [4:0]  rd_out;
  logic        wb_en_out;
  logic        illegal_out;

  modport master (
    output iw_in, pc_in, valid_in, stall, flush, wb_en, wb_reg, wb_data,
    input  iw_out, pc_out, valid_out, rs1_data, rs2_data, imm_out, rd_out,
           wb_en_out, illegal_out
  );

  modport slave (
    input  iw_in, pc_in, valid_in, stall, flush, wb_en, wb_reg, wb_data,
    output iw_out, pc_out, valid_out, rs1_data, rs2_data, imm_out, rd_out,
           wb_en_out, illegal_out
  );
endinterface

// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: 32x32 register file, immediate/field decode and the ID/EX register.
// Optional macro RV32I_DECODE_WB_BYPASS_EN: same-cycle write-back is written through to rs1/rs2 reads.
module rv32i_decode_stage #(
  parameter logic [31:0] NOP_IW   = 32'h0000_0013,
  parameter int          RF_DEPTH = 32
) (
  input logic                 clk,
  input logic                 reset,
  rv32i_decode_stage_if.slave bus
);

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_FENCE  = 7'b0001111,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_OP     = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  logic [31:0] rf [RF_DEPTH];

  logic [31:0] iw;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [4:0]  rd_idx;
  logic [31:0] rs1_rd;
  logic [31:0] rs2_rd;
  logic [31:0] imm;
  logic        legal;
  logic        fmt_writes_rd;
  logic        wb_write;
  logic        load_bubble;

  assign iw       = bus.iw_in;
  assign rs1_idx  = iw[19:15];
  assign rs2_idx  = iw[24:20];
  assign rd_idx   = iw[11:7];
  assign wb_write = bus.wb_en && (bus.wb_reg != 5'd0);

  // A bubble replaces the next ID/EX contents on flush, or on an unstalled load of an empty slot.
  assign load_bubble = bus.flush || (!bus.stall && !bus.valid_in);

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    imm           = '0;
    legal         = 1'b1;
    fmt_writes_rd = 1'b0;
    case (iw[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
        imm           = {{20{iw[31]}}, iw[31:20]};
        fmt_writes_rd = 1'b1;
      end
      OP_STORE:  imm = {{20{iw[31]}}, iw[31:25], iw[11:7]};
      OP_BRANCH: imm = {{19{iw[31]}}, iw[31], iw[7], iw[30:25], iw[11:8], 1'b0};
      OP_LUI, OP_AUIPC: begin
        imm           = {iw[31:12], 12'h000};
        fmt_writes_rd = 1'b1;
      end
      OP_JAL: begin
        imm           = {{11{iw[31]}}, iw[31], iw[19:12], iw[20], iw[30:21], 1'b0};
        fmt_writes_rd = 1'b1;
      end
      OP_OP:    fmt_writes_rd = 1'b1;
      OP_FENCE: fmt_writes_rd = 1'b0;
      default:  legal = 1'b0;
    endcase
  end

  // x0 is hardwired to zero on the read side regardless of the array contents.
  always_comb begin
    rs1_rd = (rs1_idx == 5'd0) ? '0 : rf[rs1_idx];
    rs2_rd = (rs2_idx == 5'd0) ? '0 : rf[rs2_idx];
`ifdef RV32I_DECODE_WB_BYPASS_EN
    if (wb_write && (bus.wb_reg == rs1_idx)) rs1_rd = bus.wb_data;
    if (wb_write && (bus.wb_reg == rs2_idx)) rs2_rd = bus.wb_data;
`else
    // Without write-through the old contents are returned; the pipeline stalls around the hazard.
`endif
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register file is architecturally cleared by reset, so the array is reset entry by entry.
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
      bus.iw_out      <= NOP_IW;
      bus.pc_out      <= '0;
      bus.valid_out   <= 1'b0;
      bus.rs1_data    <= '0;
      bus.rs2_data    <= '0;
      bus.imm_out     <= '0;
      bus.rd_out      <= '0;
      bus.wb_en_out   <= 1'b0;
      bus.illegal_out <= 1'b0;
    end else begin
      // Write-back is independent of stall and flush.
      if (wb_write) rf[bus.wb_reg] <= bus.wb_data;

      if (load_bubble) begin
        bus.iw_out      <= NOP_IW;
        bus.pc_out      <= bus.pc_in;
        bus.valid_out   <= 1'b0;
        bus.rs1_data    <= '0;
        bus.rs2_data    <= '0;
        bus.imm_out     <= '0;
        bus.rd_out      <= '0;
        bus.wb_en_out   <= 1'b0;
        bus.illegal_out <= 1'b0;
      end else if (!bus.stall) begin
        bus.iw_out      <= iw;
        bus.pc_out      <= bus.pc_in;
        bus.valid_out   <= 1'b1;
        bus.rs1_data    <= rs1_rd;
        bus.rs2_data    <= rs2_rd;
        bus.imm_out     <= imm;
        bus.rd_out      <= rd_idx;
        bus.wb_en_out   <= legal && fmt_writes_rd && (rd_idx != 5'd0);
        bus.illegal_out <= !legal;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Self-checking bench for rv32i_decode_stage: directed scenarios followed by randomized traffic,
// each cycle compared against a behavioural model of the register file and ID/EX register.
module tb_rv32i_decode_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rv32i_decode_stage_if bus ();

  rv32i_decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Behavioural model state
  logic [31:0] m_rf [32];
  logic [31:0] e_iw, e_pc, e_rs1, e_rs2, e_imm;
  logic [4:0]  e_rd;
  logic        e_valid, e_wb, e_ill;

  logic [6:0] opc_pool [12] = '{7'b0000011, 7'b0001111, 7'b0010011, 7'b0010111,
                                7'b0100011, 7'b0110011, 7'b0110111, 7'b1100011,
                                7'b1100111, 7'b1101111, 7'b1110011, 7'b1111111};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Immediate value as the ISA defines it, built from signed arithmetic on the word.
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    logic signed [31:0] s;
    s = $signed(w);
    case (w[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: return 32'(s >>> 20);
      7'b0100011: return 32'((s >>> 25) <<< 5) | 32'(w[11:7]);
      7'b1100011: return 32'((s >>> 31) <<< 12) | (32'(w[7]) << 11) |
                         (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      7'b0110111, 7'b0010111: return w & 32'hFFFF_F000;
      7'b1101111: return 32'((s >>> 31) <<< 20) | (32'(w[19:12]) << 12) |
                         (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_legal(input logic [6:0] op);
    return op inside {7'b0000011, 7'b0001111, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110011,
                      7'b0110111, 7'b1100011, 7'b1100111, 7'b1101111, 7'b1110011};
  endfunction

  function automatic logic ref_writes_rd(input logic [31:0] w);
    return (w[11:7] != 5'd0) &&
           (w[6:0] inside {7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011,
                           7'b0110111, 7'b0010111, 7'b1101111});
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef RV32I_DECODE_WB_BYPASS_EN
    if (bus.wb_en && bus.wb_reg == idx) return bus.wb_data;
`endif
    return m_rf[idx];
  endfunction

  task automatic model_bubble();
    e_iw = NOP; e_pc = bus.pc_in; e_valid = 1'b0; e_rs1 = '0; e_rs2 = '0;
    e_imm = '0; e_rd = '0; e_wb = 1'b0; e_ill = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".iw"},    bus.iw_out,      e_iw);
    check({tag, ".pc"},    bus.pc_out,      e_pc);
    check({tag, ".valid"}, 32'(bus.valid_out),   32'(e_valid));
    check({tag, ".rs1"},   bus.rs1_data,    e_rs1);
    check({tag, ".rs2"},   bus.rs2_data,    e_rs2);
    check({tag, ".imm"},   bus.imm_out,     e_imm);
    check({tag, ".rd"},    32'(bus.rd_out),      32'(e_rd));
    check({tag, ".wb"},    32'(bus.wb_en_out),   32'(e_wb));
    check({tag, ".ill"},   32'(bus.illegal_out), 32'(e_ill));
  endtask

  // Predict the effect of the coming edge from the current inputs, take the edge, then compare.
  task automatic tick(input string tag);
    logic [31:0] w;
    logic [31:0] r1, r2;
    w  = bus.iw_in;
    r1 = ref_read(w[19:15]);
    r2 = ref_read(w[24:20]);
    if (reset) begin
      foreach (m_rf[i]) m_rf[i] = '0;
      e_iw = NOP; e_pc = '0; e_valid = 1'b0; e_rs1 = '0; e_rs2 = '0;
      e_imm = '0; e_rd = '0; e_wb = 1'b0; e_ill = 1'b0;
    end else begin
      if (bus.flush || (!bus.valid_in && !bus.stall)) model_bubble();
      else if (!bus.stall) begin
        e_iw = w; e_pc = bus.pc_in; e_valid = 1'b1; e_rs1 = r1; e_rs2 = r2;
        e_imm = ref_imm(w); e_rd = w[11:7];
        e_wb  = ref_writes_rd(w); e_ill = !ref_legal(w[6:0]);
      end
      if (bus.wb_en && bus.wb_reg != 5'd0) m_rf[bus.wb_reg] = bus.wb_data;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic [31:0] iw, input logic [31:0] pc, input logic valid,
                       input logic st, input logic fl, input logic we,
                       input logic [4:0] wr, input logic [31:0] wd);
    bus.iw_in = iw; bus.pc_in = pc; bus.valid_in = valid; bus.stall = st; bus.flush = fl;
    bus.wb_en = we; bus.wb_reg = wr; bus.wb_data = wd;
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] x5_expect;
    foreach (m_rf[i]) m_rf[i] = '0;
    reset = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
    tick("reset");
    check("reset_iw", bus.iw_out, 32'h0000_0013);
    check("reset_valid", 32'(bus.valid_out), 32'd0);
    reset = 1'b0;

    // addi x1,x0,5
    drive(32'h0050_0093, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick("addi");
    check("addi_imm", bus.imm_out, 32'd5);
    check("addi_rd", 32'(bus.rd_out), 32'd1);
    check("addi_wben", 32'(bus.wb_en_out), 32'd1);
    check("addi_pc", bus.pc_out, 32'h8);

    // write x2, then read it with add x3,x1,x2
    drive(32'h0, 32'hC, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'hDEAD_BEEF);
    tick("wb_x2");
    drive(32'h0020_81B3, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick("add");
    check("add_rs2", bus.rs2_data, 32'hDEAD_BEEF);

    // write to x0 is discarded, both same cycle and afterwards
    drive(32'h0000_0033, 32'h14, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h1234);
    tick("wb_x0_same");
    drive(32'h0000_0033, 32'h18, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick("wb_x0_after");
    check("x0_rs1", bus.rs1_data, 32'd0);

    // beq x0,x0,-4 and lui x5,0x12345
    drive(32'hFE00_0EE3, 32'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick("beq");
    check("beq_imm", bus.imm_out, 32'hFFFF_FFFC);
    check("beq_wben", 32'(bus.wb_en_out), 32'd0);
    drive(32'h1234_52B7, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick("lui");
    check("lui_imm", bus.imm_out, 32'h1234_5000);

    // hold through a 3-cycle stall while iw_in changes; write-back still lands
    drive(32'h0050_0093, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick("pre_stall");
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h99);
      tick("stall");
      check("stall_iw", bus.iw_out, 32'h0050_0093);
      check("stall_pc", bus.pc_out, 32'h40);
    end
    drive(32'h0050_0093, 32'h44, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    tick("stall_flush");
    check("flush_iw", bus.iw_out, 32'h0000_0013);
    check("flush_valid", 32'(bus.valid_out), 32'd0);
    drive(32'h0004_8013, 32'h48, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick("read_x9");
    check("x9_written_in_stall", bus.rs1_data, 32'h99);

    // same-cycle write-back of x5 with addi x6,x5,0
`ifdef RV32I_DECODE_WB_BYPASS_EN
    x5_expect = 32'hA5A5_A5A5;
`else
    x5_expect = 32'h0;
`endif
    drive(32'h0002_8313, 32'h4C, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hA5A5_A5A5);
    tick("bypass");
    check("bypass_rs1", bus.rs1_data, x5_expect);
    drive(32'h0002_8313, 32'h50, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick("after_bypass");
    check("x5_rs1", bus.rs1_data, 32'hA5A5_A5A5);

    // illegal opcode still propagates
    drive(32'h0000_007F, 32'h54, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick("illegal");
    check("illegal_flag", 32'(bus.illegal_out), 32'd1);
    check("illegal_iw", bus.iw_out, 32'h0000_007F);

    // reset mid-stream clears the register file, even with stall/flush/write-back active
    drive(32'h0, 32'h58, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h55);
    tick("wb_x7");
    drive(32'h0003_8013, 32'h5C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick("read_x7");
    check("x7_before_reset", bus.rs1_data, 32'h55);
    reset = 1'b1;
    drive(32'h0003_8013, 32'h60, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 32'h77);
    tick("mid_reset");
    check("mid_reset_iw", bus.iw_out, 32'h0000_0013);
    check("mid_reset_pc", bus.pc_out, 32'h0);
    reset = 1'b0;
    drive(32'h0003_8013, 32'h64, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick("x7_after_reset");
    check("x7_cleared", bus.rs1_data, 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      w = $urandom;
      w[6:0] = opc_pool[$urandom_range(11, 0)];
      if ($urandom_range(9, 0) == 0) w[6:0] = 7'($urandom);
      reset = ($urandom_range(59, 0) == 0);
      drive(w, $urandom, ($urandom_range(7, 0) != 0), ($urandom_range(4, 0) == 0),
            ($urandom_range(7, 0) == 0), 1'($urandom), 5'($urandom), $urandom);
      case ($urandom_range(3, 0))
        0: bus.wb_reg = w[19:15];
        1: bus.wb_reg = w[24:20];
        default: ;
      endcase
      tick("rand");
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
